cache_line_fill: RTL and testbench

Memory-side refill engine for the direct-mapped data cache. On a cache miss it accepts the missing line address, fetches every 32-bit word of that line from backing memory over a req/ack interface, and streams the words into the cache's line storage. Words are fetched critical-word-first with wrap-around. The cache marks the line valid only on `fill_done`, so an aborted or reset fill never leaves a valid partial line.

---
 rtl/cache_line_fill.sv | 110 +++++++++++
 tb/tb_cache_line_fill.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_fill.sv
// rtl/cache_line_fill.sv - critical-word-first cache line refill engine
module cache_line_fill #(
  parameter int LOG_NUM_BYTES_PER_LINE = 5,
  parameter bit CRITICAL_FIRST         = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              miss_valid,
  input  logic [31:0]                       miss_addr,
  output logic                              miss_ready,
  output logic                              mem_req,
  output logic [31:0]                       mem_addr,
  input  logic                              mem_ack,
  input  logic [31:0]                       mem_rdata,
  input  logic                              mem_err,
  output logic                              fill_we,
  output logic [LOG_NUM_BYTES_PER_LINE-3:0] fill_word,
  output logic [31:0]                       fill_data,
  output logic [31:0]                       fill_line,
  output logic                              crit_valid,
  output logic                              fill_done,
  output logic                              fill_err
);

  localparam int LB = LOG_NUM_BYTES_PER_LINE;
  localparam int WW = LOG_NUM_BYTES_PER_LINE - 2;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t        state;
  logic [WW-1:0] word;
  logic [WW-1:0] beats;
  logic [WW-1:0] word_nxt;
  logic [WW-1:0] start;
  logic          unused_addr_bits;

  assign word_nxt         = word + 1'b1;
  assign start            = CRITICAL_FIRST ? miss_addr[LB-1:2] : '0;
  assign unused_addr_bits = ^miss_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word       <= '0;
      beats      <= '0;
      miss_ready <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_we    <= 1'b0;
      fill_word  <= '0;
      fill_data  <= '0;
      fill_line  <= '0;
      crit_valid <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
    end else begin
      fill_we    <= 1'b0;
      crit_valid <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      case (state)
        IDLE: begin
          // miss_ready is registered, so it comes up one cycle after entering IDLE
          if (miss_valid && miss_ready) begin
            miss_ready <= 1'b0;
            fill_line  <= {miss_addr[31:LB], {LB{1'b0}}};
            word       <= start;
            beats      <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= {miss_addr[31:LB], start, 2'b00};
            state      <= BURST;
          end else begin
            miss_ready <= 1'b1;
          end
        end
        BURST: begin
          if (mem_ack) begin
            if (mem_err) begin
              mem_req  <= 1'b0;
              mem_addr <= '0;
              fill_err <= 1'b1;
              state    <= IDLE;
            end else begin
              fill_we    <= 1'b1;
              fill_word  <= word;
              fill_data  <= mem_rdata;
              crit_valid <= (beats == '0);
              word       <= word_nxt;
              beats      <= beats + 1'b1;
              if (&beats) begin
                mem_req   <= 1'b0;
                mem_addr  <= '0;
                fill_done <= 1'b1;
                state     <= DONE;
              end else begin
                mem_addr <= {fill_line[31:LB], word_nxt, 2'b00};
              end
            end
          end
        end
        DONE: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_fill.sv
// tb/tb_cache_line_fill.sv - directed vector bench for cache_line_fill
module tb_cache_line_fill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, miss_valid, mem_ack, mem_err;
  logic [31:0] miss_addr, mem_rdata;

  logic        a_miss_ready, a_mem_req, a_fill_we, a_crit_valid, a_fill_done, a_fill_err;
  logic [31:0] a_mem_addr, a_fill_data, a_fill_line;
  logic [2:0]  a_fill_word;
  logic        b_miss_ready, b_mem_req, b_fill_we, b_crit_valid, b_fill_done, b_fill_err;
  logic [31:0] b_mem_addr, b_fill_data, b_fill_line;
  logic [2:0]  b_fill_word;

  cache_line_fill #(.LOG_NUM_BYTES_PER_LINE(5), .CRITICAL_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid & ~sel), .miss_addr(miss_addr), .miss_ready(a_miss_ready),
    .mem_req(a_mem_req), .mem_addr(a_mem_addr),
    .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .fill_we(a_fill_we), .fill_word(a_fill_word), .fill_data(a_fill_data),
    .fill_line(a_fill_line), .crit_valid(a_crit_valid),
    .fill_done(a_fill_done), .fill_err(a_fill_err)
  );

  cache_line_fill #(.LOG_NUM_BYTES_PER_LINE(5), .CRITICAL_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid & sel), .miss_addr(miss_addr), .miss_ready(b_miss_ready),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr),
    .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .fill_we(b_fill_we), .fill_word(b_fill_word), .fill_data(b_fill_data),
    .fill_line(b_fill_line), .crit_valid(b_crit_valid),
    .fill_done(b_fill_done), .fill_err(b_fill_err)
  );

  logic        o_miss_ready, o_mem_req, o_fill_we, o_crit_valid, o_fill_done, o_fill_err;
  logic [31:0] o_mem_addr, o_fill_data, o_fill_line;
  logic [2:0]  o_fill_word;

  assign o_miss_ready = sel ? b_miss_ready : a_miss_ready;
  assign o_mem_req    = sel ? b_mem_req    : a_mem_req;
  assign o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
  assign o_fill_we    = sel ? b_fill_we    : a_fill_we;
  assign o_fill_word  = sel ? b_fill_word  : a_fill_word;
  assign o_fill_data  = sel ? b_fill_data  : a_fill_data;
  assign o_fill_line  = sel ? b_fill_line  : a_fill_line;
  assign o_crit_valid = sel ? b_crit_valid : a_crit_valid;
  assign o_fill_done  = sel ? b_fill_done  : a_fill_done;
  assign o_fill_err   = sel ? b_fill_err   : a_fill_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [31:0] q_ack_addr[$];
  logic [31:0] q_data[$];
  int          q_word[$];
  int n_we, n_done, n_err, n_crit, crit_word, done_word, done_cyc, err_cyc;
  int ready_cyc, last_ack_cyc, held_bad;
  logic [31:0] line_seen;

  // Zero-wait when gap=0; otherwise gap idle cycles precede each ack. err_ack=N errors the Nth ack.
  task automatic run_fill(input logic [31:0] addr, input int gap, input int err_ack);
    int cyc, acks, wcnt, guard;
    bit fin, acked_prev, prev_req;
    logic [31:0] prev_addr;
    q_ack_addr.delete(); q_data.delete(); q_word.delete();
    n_we = 0; n_done = 0; n_err = 0; n_crit = 0; crit_word = -1; done_word = -1;
    done_cyc = -1; err_cyc = -1; ready_cyc = -1; last_ack_cyc = -1; held_bad = 0;
    @(negedge clk);
    miss_addr = addr; miss_valid = 1'b1; mem_ack = 1'b0; mem_err = 1'b0;
    guard = 0;
    while (!o_miss_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", o_miss_ready, 1);
    @(negedge clk);
    miss_valid = 1'b0;
    line_seen = o_fill_line;
    cyc = 1; acks = 0; wcnt = 0; fin = 0; prev_req = 0; acked_prev = 0; prev_addr = '0;
    while (!fin && cyc < 300) begin
      if (o_fill_we) begin
        n_we++;
        q_word.push_back(int'(o_fill_word));
        q_data.push_back(o_fill_data);
      end
      if (o_crit_valid) begin n_crit++; crit_word = int'(o_fill_word); end
      if (o_fill_done) begin n_done++; done_word = int'(o_fill_word); done_cyc = cyc; end
      if (o_fill_err) begin n_err++; err_cyc = cyc; end
      if (o_mem_req && prev_req && !acked_prev && o_mem_addr !== prev_addr) held_bad++;
      if ((done_cyc >= 0 || err_cyc >= 0) && o_miss_ready) begin ready_cyc = cyc; fin = 1; end
      prev_req = o_mem_req; prev_addr = o_mem_addr; acked_prev = 0;
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = o_mem_addr;
      if (!fin && o_mem_req) begin
        if (wcnt >= gap) begin
          acks++;
          mem_ack = 1'b1;
          mem_err = (acks == err_ack);
          q_ack_addr.push_back(o_mem_addr);
          last_ack_cyc = cyc; acked_prev = 1; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("fill_timeout", fin, 1);
    mem_ack = 1'b0; mem_err = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    int          gap;
    int          err_ack;
    int          exp_first;
    int          exp_we;
    bit          exp_done;
    logic [31:0] exp_line;
  } vec_t;

  vec_t        vec[7];
  logic [31:0] k_addr[8];
  int          k_word[8];

  initial begin
    int w, cnt, guard, sawdone;
    logic [31:0] ea;

    vec[0] = '{1'b0, 32'h0000_1234, 0, 0, 5, 8, 1'b1, 32'h0000_1220};
    vec[1] = '{1'b0, 32'h0000_1234, 2, 0, 5, 8, 1'b1, 32'h0000_1220};
    vec[2] = '{1'b1, 32'h0000_0F1C, 0, 0, 0, 8, 1'b1, 32'h0000_0F00};
    vec[3] = '{1'b0, 32'h0000_1234, 0, 3, 5, 2, 1'b0, 32'h0000_1220};
    vec[4] = '{1'b0, 32'h0000_001C, 1, 0, 7, 8, 1'b1, 32'h0000_0000};
    vec[5] = '{1'b0, 32'hFFFF_FFE0, 0, 0, 0, 8, 1'b1, 32'hFFFF_FFE0};
    vec[6] = '{1'b1, 32'h0000_0F04, 1, 1, 0, 0, 1'b0, 32'h0000_0F00};
    k_addr = '{32'h1234, 32'h1238, 32'h123C, 32'h1220, 32'h1224, 32'h1228, 32'h122C, 32'h1230};
    k_word = '{5, 6, 7, 0, 1, 2, 3, 4};

    rst = 1'b1; sel = 1'b0; miss_valid = 1'b1; miss_addr = 32'h0000_1234;
    mem_ack = 1'b1; mem_err = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_ctrl", {a_miss_ready, a_mem_req, a_fill_we, a_crit_valid, a_fill_done, a_fill_err}, 0);
    chk("rst_a_data", {a_mem_addr, a_fill_data, a_fill_line, a_fill_word}, 0);
    chk("rst_b_ctrl", {b_miss_ready, b_mem_req, b_fill_we, b_crit_valid, b_fill_done, b_fill_err}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", a_miss_ready, 1);
    chk("rel_no_req", a_mem_req, 0);
    miss_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("rel_idle_req", a_mem_req, 0);

    for (int v = 0; v < 7; v++) begin
      sel = vec[v].sel;
      run_fill(vec[v].addr, vec[v].gap, vec[v].err_ack);
      chk($sformatf("v%0d_n_we", v), n_we, vec[v].exp_we);
      chk($sformatf("v%0d_n_done", v), n_done, vec[v].exp_done ? 1 : 0);
      chk($sformatf("v%0d_n_err", v), n_err, vec[v].exp_done ? 0 : 1);
      chk($sformatf("v%0d_n_crit", v), n_crit, (vec[v].exp_we > 0) ? 1 : 0);
      chk($sformatf("v%0d_line", v), line_seen, vec[v].exp_line);
      chk($sformatf("v%0d_held", v), held_bad, 0);
      chk($sformatf("v%0d_n_acks", v), q_ack_addr.size(), vec[v].exp_done ? 8 : vec[v].err_ack);
      if (vec[v].exp_we > 0) chk($sformatf("v%0d_crit_word", v), crit_word, vec[v].exp_first);
      if (vec[v].exp_done) begin
        chk($sformatf("v%0d_done_word", v), done_word, (vec[v].exp_first + 7) % 8);
        chk($sformatf("v%0d_done_cyc", v), done_cyc, last_ack_cyc + 1);
        chk($sformatf("v%0d_ready_cyc", v), ready_cyc, done_cyc + 1);
      end else begin
        chk($sformatf("v%0d_err_cyc", v), err_cyc, last_ack_cyc + 1);
        chk($sformatf("v%0d_ready_cyc", v), ready_cyc, err_cyc + 1);
      end
      for (int i = 0; i < q_ack_addr.size(); i++) begin
        w = (vec[v].exp_first + i) % 8;
        ea = vec[v].exp_line | (w << 2);
        chk($sformatf("v%0d_addr%0d", v, i), q_ack_addr[i], ea);
      end
      for (int i = 0; i < q_word.size(); i++) begin
        w = (vec[v].exp_first + i) % 8;
        ea = vec[v].exp_line | (w << 2);
        chk($sformatf("v%0d_word%0d", v, i), q_word[i], w);
        chk($sformatf("v%0d_data%0d", v, i), q_data[i], ea);
      end
      if (v == 0) begin
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("k_addr%0d", i), (i < q_ack_addr.size()) ? q_ack_addr[i] : 32'hFFFF_FFFF, k_addr[i]);
          chk($sformatf("k_word%0d", i), (i < q_word.size()) ? q_word[i] : -1, k_word[i]);
        end
      end
      if (v == 2) chk("cf0_done_cyc", done_cyc, 9);
    end

    // Reset in the middle of a burst, right after the 4th beat is written.
    sel = 1'b0;
    @(negedge clk);
    miss_addr = 32'h0000_1234; miss_valid = 1'b1;
    guard = 0;
    while (!o_miss_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cnt = 0; sawdone = 0; guard = 0;
    while (cnt < 4 && guard < 50) begin
      @(negedge clk);
      guard++;
      miss_valid = 1'b0;
      if (o_fill_we) cnt++;
      if (o_fill_done) sawdone++;
      mem_ack = (cnt < 4) && o_mem_req;
      mem_rdata = o_mem_addr;
    end
    chk("mid_beats", cnt, 4);
    rst = 1'b0;
    #1;
    chk("mid_req_drop", o_mem_req, 0);
    chk("mid_we_drop", o_fill_we, 0);
    chk("mid_done_drop", o_fill_done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (o_fill_done || o_fill_err) sawdone++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (o_fill_done || o_fill_err) sawdone++;
    chk("mid_no_done", sawdone, 0);
    run_fill(32'h0000_1238, 0, 0);
    chk("post_rst_first_word", (q_word.size() > 0) ? q_word[0] : -1, 6);
    chk("post_rst_crit", crit_word, 6);
    chk("post_rst_n_we", n_we, 8);
    chk("post_rst_done", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
